fpu_norm_shift: RTL and testbench

Pipelined normalizer for the private FPU. It consumes an unnormalized mantissa and its biased exponent and performs an MSB-first leading-one search. It then left-shifts the mantissa so the leading one lands at bit LEN-1, and lowers the exponent by the shift amount, clamping to the denormal encoding when the exponent would underflow. It sits between the adder/multiplier datapath and the rounding stage, behind a valid/ready handshake on both sides.

---
 rtl/fpu_norm_shift.sv | 118 +++++++++++
 tb/tb_fpu_norm_shift.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_norm_shift.sv
// Two-stage mantissa normalizer: leading-one search, left shift, exponent adjust.
// Ports: valid_i/ready_o/mant_i/exp_i in; valid_o/ready_i/mant_o/exp_o/zero_o/denorm_o out.
module fpu_norm_shift #(
  parameter int LEN   = 32,
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [LEN-1:0]   mant_i,
  input  logic [EXP_W-1:0] exp_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [LEN-1:0]   mant_o,
  output logic [EXP_W-1:0] exp_o,
  output logic             zero_o,
  output logic             denorm_o
);

  localparam int LZ_W = $clog2(LEN);
  localparam int XW   = EXP_W + 1;

  logic             s1_valid;
  logic [LEN-1:0]   s1_mant;
  logic [EXP_W-1:0] s1_exp;
  logic [LZ_W-1:0]  s1_lz;

  logic [LZ_W-1:0]  lz;
  logic             found;

  logic             s2_free;
  logic             s1_advance;
  logic             accept;

  logic [XW-1:0]    exp_x;
  logic [XW-1:0]    lz_x;
  logic [XW-1:0]    shift;
  logic [EXP_W-1:0] n_exp;
  logic [LEN-1:0]   n_mant;
  logic             n_zero;
  logic             n_den;

  assign s2_free    = ~valid_o | ready_i;
  assign s1_advance = s1_valid & s2_free;
  assign ready_o    = ~rst & (~s1_valid | s1_advance);
  assign accept     = valid_i & ready_o;

  // MSB-first search; value for an all-zero mantissa is irrelevant
  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = LEN - 1; i >= 0; i--) begin
      if (!found && mant_i[i]) begin
        lz    = LZ_W'(LEN - 1 - i);
        found = 1'b1;
      end
    end
  end

  assign exp_x = XW'(s1_exp);
  assign lz_x  = XW'(s1_lz);

  // When the exponent cannot absorb the full shift, stop at exp 1
  // and encode the result as denormal (exp 0).
  always_comb begin
    shift  = '0;
    n_exp  = '0;
    n_zero = 1'b0;
    n_den  = 1'b0;
    if (s1_mant == '0) begin
      n_zero = 1'b1;
    end else if (exp_x > lz_x) begin
      shift = lz_x;
      n_exp = EXP_W'(exp_x - lz_x);
    end else if (exp_x != '0) begin
      shift = exp_x - XW'(1);
      n_den = 1'b1;
    end else begin
      n_den = 1'b1;
    end
  end

  assign n_mant = s1_mant << shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_exp   <= '0;
      s1_lz    <= '0;
      valid_o  <= 1'b0;
      mant_o   <= '0;
      exp_o    <= '0;
      zero_o   <= 1'b0;
      denorm_o <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_mant  <= mant_i;
        s1_exp   <= exp_i;
        s1_lz    <= lz;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end
      if (s1_advance) begin
        valid_o  <= 1'b1;
        mant_o   <= n_mant;
        exp_o    <= n_exp;
        zero_o   <= n_zero;
        denorm_o <= n_den;
      end else if (ready_i) begin
        valid_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_norm_shift.sv
// Bench for fpu_norm_shift: directed vectors, streaming,
// backpressure, random ready and mid-stream reset.
module tb_fpu_norm_shift;

  localparam int LEN   = 32;
  localparam int EXP_W = 8;

  typedef struct packed {
    logic [LEN-1:0]   mant;
    logic [EXP_W-1:0] exp;
    logic             zero;
    logic             denorm;
  } res_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [LEN-1:0]   mant_i = '0;
  logic [EXP_W-1:0] exp_i = '0;
  logic             valid_o;
  logic             ready_i = 1'b1;
  logic [LEN-1:0]   mant_o;
  logic [EXP_W-1:0] exp_o;
  logic             zero_o;
  logic             denorm_o;

  int   checks = 0;
  int   errors = 0;
  int   stalls = 0;
  int   acc    = 0;
  bit   rand_rdy = 1'b0;
  bit   stall_prev = 1'b0;
  res_t hold;
  res_t q[$];

  fpu_norm_shift #(.LEN(LEN), .EXP_W(EXP_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .mant_i  (mant_i),
    .exp_i   (exp_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .mant_o  (mant_o),
    .exp_o   (exp_o),
    .zero_o  (zero_o),
    .denorm_o(denorm_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: shift one bit at a time while exponent stays >= 1
  function automatic res_t model(input logic [LEN-1:0] m,
                                 input logic [EXP_W-1:0] e);
    res_t r;
    int   ev;
    r  = '0;
    ev = int'(e);
    if (m == '0) begin
      r.zero = 1'b1;
    end else if (ev == 0) begin
      r.mant   = m;
      r.denorm = 1'b1;
    end else begin
      while (!m[LEN-1] && ev > 1) begin
        m  = m << 1;
        ev = ev - 1;
      end
      r.mant = m;
      if (m[LEN-1]) r.exp = EXP_W'(ev);
      else r.denorm = 1'b1;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    res_t r;
    if (rst) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_mant", 64'(mant_o), 64'(hold.mant));
        chk("hold_exp", 64'(exp_o), 64'(hold.exp));
        chk("hold_flags", {62'd0, zero_o, denorm_o},
            {62'd0, hold.zero, hold.denorm});
      end
      if (valid_o && ready_i) begin
        chk("result_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          r = q.pop_front();
          chk("mant_o", 64'(mant_o), 64'(r.mant));
          chk("exp_o", 64'(exp_o), 64'(r.exp));
          chk("zero_o", 64'(zero_o), 64'(r.zero));
          chk("denorm_o", 64'(denorm_o), 64'(r.denorm));
        end
      end
      stall_prev = valid_o && !ready_i;
      hold = '{mant_o, exp_o, zero_o, denorm_o};
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 ready_i = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [LEN-1:0] m,
                      input logic [EXP_W-1:0] e, input res_t r);
    int n;
    n = 0;
    valid_i = 1'b1;
    mant_i  = m;
    exp_i   = e;
    @(negedge clk);
    while (!ready_o && n < 200) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (ready_o) q.push_back(r);
    else chk("send_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  task automatic send_rand();
    logic [LEN-1:0]   m;
    logic [EXP_W-1:0] e;
    m = LEN'($urandom) >> $urandom_range(0, LEN - 1);
    if ($urandom_range(0, 15) == 0) m = '0;
    e = EXP_W'($urandom_range(0, 255));
    send(m, e, model(m, e));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || valid_o) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1 chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    logic [LEN-1:0]   dm [9];
    logic [EXP_W-1:0] de [9];
    res_t             dr [9];
    res_t             r;

    dm[0] = 32'h0000_8000; de[0] = 8'd100;
    dr[0] = '{32'h8000_0000, 8'd84, 1'b0, 1'b0};
    dm[1] = 32'h0000_0001; de[1] = 8'd10;
    dr[1] = '{32'h0000_0200, 8'd0, 1'b0, 1'b1};
    dm[2] = 32'h1000_0000; de[2] = 8'd3;
    dr[2] = '{32'h4000_0000, 8'd0, 1'b0, 1'b1};
    dm[3] = 32'h0000_0000; de[3] = 8'd50;
    dr[3] = '{32'h0000_0000, 8'd0, 1'b1, 1'b0};
    dm[4] = 32'h8000_0001; de[4] = 8'd0;
    dr[4] = '{32'h8000_0001, 8'd0, 1'b0, 1'b1};
    dm[5] = 32'hC000_0000; de[5] = 8'd7;
    dr[5] = '{32'hC000_0000, 8'd7, 1'b0, 1'b0};
    dm[6] = 32'h4000_0000; de[6] = 8'd2;
    dr[6] = '{32'h8000_0000, 8'd1, 1'b0, 1'b0};
    dm[7] = 32'h0000_0001; de[7] = 8'd255;
    dr[7] = '{32'h8000_0000, 8'd224, 1'b0, 1'b0};
    dm[8] = 32'hFFFF_FFFF; de[8] = 8'd1;
    dr[8] = '{32'hFFFF_FFFF, 8'd1, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_o", 64'(ready_o), 64'd0);
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_outs", {mant_o, exp_o, zero_o, denorm_o, 22'd0}, 64'd0);
    rst = 1'b0;
    #1 chk("ready_after_rst", 64'(ready_o), 64'd1);

    // single operand: latency
    send(dm[0], de[0], dr[0]);
    chk("lat_cycle1", 64'(valid_o), 64'd0);
    @(posedge clk);
    #1 chk("lat_cycle2", 64'(valid_o), 64'd1);
    drain();

    // directed table, back to back
    for (int i = 1; i < 9; i++) send(dm[i], de[i], dr[i]);
    drain();

    // streaming at full rate
    stalls = 0;
    for (int i = 0; i < 100; i++) send_rand();
    chk("stream_no_stall", 64'(stalls), 64'd0);
    drain();

    // backpressure with valid_i held high
    ready_i = 1'b0;
    acc = 0;
    valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mant_i = LEN'($urandom) >> $urandom_range(0, LEN - 1);
      exp_i  = EXP_W'($urandom_range(0, 255));
      @(negedge clk);
      if (ready_o) begin
        q.push_back(model(mant_i, exp_i));
        acc++;
      end
      @(posedge clk);
      #1;
    end
    chk("bp_accepts", 64'(acc), 64'd2);
    chk("bp_ready_low", 64'(ready_o), 64'd0);
    valid_i = 1'b0;
    ready_i = 1'b1;
    drain();

    // random downstream readiness
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) send_rand();
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 ready_i = 1'b1;
    drain();

    // reset with both stages full
    ready_i = 1'b0;
    send(32'h0000_0F00, 8'd40, model(32'h0000_0F00, 8'd40));
    send(32'h0003_0000, 8'd9, model(32'h0003_0000, 8'd9));
    @(negedge clk);
    chk("full_ready_low", 64'(ready_o), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid_o", 64'(valid_o), 64'd0);
    chk("mid_rst_outs", {mant_o, exp_o, zero_o, denorm_o, 22'd0}, 64'd0);
    chk("mid_rst_ready_o", 64'(ready_o), 64'd0);
    rst = 1'b0;
    ready_i = 1'b1;
    #1 chk("post_rst_ready", 64'(ready_o), 64'd1);
    repeat (4) @(posedge clk);
    #1 chk("no_stale_valid", 64'(valid_o), 64'd0);
    r = model(32'h0000_0003, 8'd5);
    send(32'h0000_0003, 8'd5, r);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
